mem_stage_ctrl: RTL and testbench



---
 rtl/mem_pkg.sv | 33 +++
 rtl/mem_lane_align.sv | 38 +++
 rtl/mem_stage_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the memory stage: opcodes, funct3 access codes,
// controller states and the access-size decode.
package mem_pkg;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } memState_t;

    // Access size in bytes; the low two funct3 bits select 1/2/4/8.
    function automatic logic [3:0] accessBytes(input logic [2:0] funct3);
        logic [3:0] bytes;
        case (funct3[1:0])
            2'b00:   bytes = 4'd1;
            2'b01:   bytes = 4'd2;
            2'b10:   bytes = 4'd4;
            default: bytes = 4'd8;
        endcase
        return bytes;
    endfunction
endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store mask/data placement and load extraction with
// sign or zero extension from the access MSB.
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int XLEN = 64,
    localparam int NB = XLEN / 8,
    localparam int OFF_W = $clog2(XLEN / 8)
)(
    input  logic [OFF_W-1:0] offset,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  storeData,
    input  logic [XLEN-1:0]  readData,
    output logic [NB-1:0]    wmask,
    output logic [XLEN-1:0]  wdata,
    output logic [XLEN-1:0]  loadData
);
    logic [NB-1:0]   sizeMask;
    logic [XLEN-1:0] shifted;

    assign sizeMask = NB'((32'd1 << accessBytes(funct3)) - 32'd1);
    assign wmask    = sizeMask << offset;
    assign wdata    = storeData << {offset, 3'b000};
    assign shifted  = readData >> {offset, 3'b000};

    always_comb begin
        loadData = shifted;
        case (funct3)
            F3_B:    loadData = XLEN'($signed(shifted[7:0]));
            F3_H:    loadData = XLEN'($signed(shifted[15:0]));
            F3_W:    loadData = XLEN'($signed(shifted[31:0]));
            F3_BU:   loadData = XLEN'(shifted[7:0]);
            F3_HU:   loadData = XLEN'(shifted[15:0]);
            F3_WU:   loadData = XLEN'(shifted[31:0]);
            default: loadData = shifted;
        endcase
    end
endmodule

// File: rtl/mem_stage_ctrl.sv
// Sequential memory stage: EA generation, one-in-flight memory handshake,
// access fault detection and aligned load writeback.
// state    | meaning
// IDLE     | empty, ready for an op
// REQ      | request presented, waiting for MemReqReady
// WAIT_RSP | request accepted, waiting for MemRspValid
// DONE     | result presented to WB until OutReady
module mem_stage_ctrl
    import mem_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int ADDR_W     = 64,
    parameter int REG_ADDR_W = 5
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic [XLEN-1:0]       RdWriteDataIn,
    input  logic [REG_ADDR_W-1:0] RdAddrIn,
    input  logic                  RdWriteEnableIn,
    input  logic [XLEN-1:0]       ImmIn,
    input  logic [6:0]            OpCodeIn,
    input  logic [2:0]            Funct3In,
    input  logic [XLEN-1:0]       Rs1ReadDataIn,
    input  logic [XLEN-1:0]       Rs2ReadDataIn,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [XLEN-1:0]       RdWriteDataOut,
    output logic [REG_ADDR_W-1:0] RdAddrOut,
    output logic                  RdWriteEnableOut,
    output logic                  AccessFaultOut,
    output logic                  MemReqValid,
    input  logic                  MemReqReady,
    output logic                  MemReqWrite,
    output logic [ADDR_W-1:0]     MemAddrOut,
    output logic [XLEN-1:0]       MemWdataOut,
    output logic [XLEN/8-1:0]     MemWmask,
    input  logic                  MemRspValid,
    input  logic [XLEN-1:0]       MemRdataIn
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    memState_t state, stateNext, acceptState;

    logic [ADDR_W-1:0]     eaQ;
    logic [XLEN-1:0]       rs2Q, resultQ;
    logic [REG_ADDR_W-1:0] rdAddrQ;
    logic [2:0]            funct3Q;
    logic                  isStoreQ, rdWeQ, faultQ;

    logic [XLEN-1:0]   addrSum;
    logic [ADDR_W-1:0] ea;
    logic              isLoad, isStore, illegal, misaligned, accept;
    logic [NB-1:0]     laneMask;
    logic [XLEN-1:0]   laneWdata, laneLoad;

    assign addrSum = Rs1ReadDataIn + ImmIn;
    assign ea      = addrSum[ADDR_W-1:0];
    assign isLoad  = (OpCodeIn == OP_LOAD);
    assign isStore = (OpCodeIn == OP_STORE);

    always_comb begin
        illegal = 1'b0;
        if (isLoad)
            illegal = (Funct3In == 3'b111) ||
                      ((XLEN == 32) && (Funct3In == F3_D || Funct3In == F3_WU));
        if (isStore)
            illegal = Funct3In[2] || ((XLEN == 32) && (Funct3In == F3_D));
    end

    assign misaligned  = (isLoad || isStore) &&
                         ((ea[2:0] & 3'(accessBytes(Funct3In) - 4'd1)) != 3'b000);
    assign acceptState = ((isLoad || isStore) && !illegal && !misaligned) ? REQ : DONE;
    assign InReady     = (state == IDLE) || (state == DONE && OutReady);
    assign accept      = InValid && InReady;

    mem_lane_align #(.XLEN(XLEN)) u_lane (
        .offset    (eaQ[OFF_W-1:0]),
        .funct3    (funct3Q),
        .storeData (rs2Q),
        .readData  (MemRdataIn),
        .wmask     (laneMask),
        .wdata     (laneWdata),
        .loadData  (laneLoad)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext        = state;
        OutValid         = 1'b0;
        RdWriteDataOut   = '0;
        RdAddrOut        = '0;
        RdWriteEnableOut = 1'b0;
        AccessFaultOut   = 1'b0;
        MemReqValid      = 1'b0;
        MemReqWrite      = 1'b0;
        MemAddrOut       = '0;
        MemWdataOut      = '0;
        MemWmask         = '0;
        case (state)
            IDLE: if (accept) stateNext = acceptState;
            REQ: begin
                MemReqValid = 1'b1;
                MemReqWrite = isStoreQ;
                MemAddrOut  = eaQ;
                MemWdataOut = isStoreQ ? laneWdata : '0;
                MemWmask    = laneMask;
                if (MemReqReady) stateNext = WAIT_RSP;
            end
            WAIT_RSP: if (MemRspValid) stateNext = DONE;
            DONE: begin
                OutValid         = 1'b1;
                RdWriteDataOut   = resultQ;
                RdAddrOut        = rdAddrQ;
                RdWriteEnableOut = rdWeQ;
                AccessFaultOut   = faultQ;
                if (accept)        stateNext = acceptState;
                else if (OutReady) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Faulting and store ops never write the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eaQ      <= '0;
            rs2Q     <= '0;
            resultQ  <= '0;
            rdAddrQ  <= '0;
            funct3Q  <= '0;
            isStoreQ <= 1'b0;
            rdWeQ    <= 1'b0;
            faultQ   <= 1'b0;
        end else if (accept) begin
            eaQ      <= ea;
            rs2Q     <= Rs2ReadDataIn;
            rdAddrQ  <= RdAddrIn;
            funct3Q  <= Funct3In;
            isStoreQ <= isStore;
            if (!(isLoad || isStore)) begin
                resultQ <= RdWriteDataIn;
                rdWeQ   <= RdWriteEnableIn;
                faultQ  <= 1'b0;
            end else if (illegal || misaligned) begin
                resultQ <= '0;
                rdWeQ   <= 1'b0;
                faultQ  <= 1'b1;
            end else begin
                resultQ <= '0;
                rdWeQ   <= isLoad && RdWriteEnableIn;
                faultQ  <= 1'b0;
            end
        end else if (state == WAIT_RSP && MemRspValid && !isStoreQ) begin
            resultQ <= laneLoad;
        end
    end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl (XLEN=64): directed scenarios plus
// randomized ops checked against an arithmetic reference model.
module tb_mem_stage_ctrl;
    localparam logic [6:0] OPC_LD  = 7'b0000011;
    localparam logic [6:0] OPC_ST  = 7'b0100011;
    localparam logic [6:0] OPC_ALU = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        InValid, InReady;
    logic [63:0] RdWriteDataIn;
    logic [4:0]  RdAddrIn;
    logic        RdWriteEnableIn;
    logic [63:0] ImmIn;
    logic [6:0]  OpCodeIn;
    logic [2:0]  Funct3In;
    logic [63:0] Rs1ReadDataIn, Rs2ReadDataIn;
    logic        OutValid, OutReady;
    logic [63:0] RdWriteDataOut;
    logic [4:0]  RdAddrOut;
    logic        RdWriteEnableOut, AccessFaultOut;
    logic        MemReqValid, MemReqReady, MemReqWrite;
    logic [63:0] MemAddrOut, MemWdataOut;
    logic [7:0]  MemWmask;
    logic        MemRspValid;
    logic [63:0] MemRdataIn;

    int checks = 0;
    int errors = 0;

    logic        obsReq, obsWrite, obsStable, obsWe, obsFault, obsDone;
    logic [63:0] obsAddr, obsWdata, obsData;
    logic [7:0]  obsMask;
    logic [4:0]  obsRd;
    int          obsDoneCyc;

    logic [209:0] allOuts;
    assign allOuts = {OutValid, RdWriteDataOut, RdAddrOut, RdWriteEnableOut, AccessFaultOut,
                      MemReqValid, MemReqWrite, MemAddrOut, MemWdataOut, MemWmask};

    always #5 clk = ~clk;

    mem_stage_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .InValid(InValid), .InReady(InReady),
        .RdWriteDataIn(RdWriteDataIn), .RdAddrIn(RdAddrIn), .RdWriteEnableIn(RdWriteEnableIn),
        .ImmIn(ImmIn), .OpCodeIn(OpCodeIn), .Funct3In(Funct3In),
        .Rs1ReadDataIn(Rs1ReadDataIn), .Rs2ReadDataIn(Rs2ReadDataIn),
        .OutValid(OutValid), .OutReady(OutReady),
        .RdWriteDataOut(RdWriteDataOut), .RdAddrOut(RdAddrOut),
        .RdWriteEnableOut(RdWriteEnableOut), .AccessFaultOut(AccessFaultOut),
        .MemReqValid(MemReqValid), .MemReqReady(MemReqReady), .MemReqWrite(MemReqWrite),
        .MemAddrOut(MemAddrOut), .MemWdataOut(MemWdataOut), .MemWmask(MemWmask),
        .MemRspValid(MemRspValid), .MemRdataIn(MemRdataIn)
    );

    // Reference behaviour computed directly from the access rules.
    function automatic void model(input logic [6:0] op, input logic [2:0] f3,
                                  input logic [63:0] rs1, input logic [63:0] imm,
                                  input logic [63:0] rs2, input logic [63:0] rdata,
                                  input logic [63:0] alu, input logic we,
                                  output logic expReq, output logic expFault, output logic expWe,
                                  output logic [63:0] expAddr, output logic [63:0] expWdata,
                                  output logic [63:0] expData, output logic [7:0] expMask);
        logic [63:0] ea, raw, lim;
        logic        isLd, isSt, bad;
        int          size, off, bits;
        ea   = rs1 + imm;
        isLd = (op == OPC_LD);
        isSt = (op == OPC_ST);
        size = 1 << f3[1:0];
        off  = int'(ea % 8);
        bad  = (isLd && f3 == 3'd7) || (isSt && f3 >= 3'd4) || ((ea % 64'(size)) != 0);
        expFault = (isLd || isSt) && bad;
        expReq   = (isLd || isSt) && !bad;
        expAddr  = ea;
        expMask  = 8'(((1 << size) - 1) << off);
        expWdata = rs2 << (8 * off);
        raw  = rdata >> (8 * off);
        bits = 8 * size;
        if (bits < 64) begin
            lim = (64'd1 << bits) - 64'd1;
            raw = raw & lim;
            if (!f3[2] && raw[bits-1]) raw = raw | ~lim;
        end
        expData = isLd ? raw : alu;
        expWe   = (expFault || isSt) ? 1'b0 : we;
    endfunction

    // Issues one op from IDLE, plays the memory side, and records what was seen.
    task automatic do_op(input logic [6:0] op, input logic [2:0] f3, input logic [63:0] rs1,
                         input logic [63:0] imm, input logic [63:0] rs2, input logic [63:0] alu,
                         input logic [4:0] rd, input logic we, input int reqWait, input int rspWait,
                         input logic spur, input logic [63:0] rdata);
        int reqCnt = 0;
        OpCodeIn = op; Funct3In = f3; Rs1ReadDataIn = rs1; ImmIn = imm; Rs2ReadDataIn = rs2;
        RdWriteDataIn = alu; RdAddrIn = rd; RdWriteEnableIn = we; OutReady = 1'b0; InValid = 1'b1;
        obsReq = 1'b0; obsStable = 1'b1; obsDone = 1'b0; obsDoneCyc = -1;
        @(posedge clk); #1;
        InValid = 1'b0;
        for (int cyc = 0; cyc < 60 && !obsDone; cyc++) begin
            @(negedge clk);
            if (OutValid) begin
                obsDone = 1'b1; obsDoneCyc = cyc; obsData = RdWriteDataOut; obsRd = RdAddrOut;
                obsWe = RdWriteEnableOut; obsFault = AccessFaultOut;
            end else begin
                if (MemReqValid) begin
                    if (!obsReq) begin
                        obsReq = 1'b1; obsAddr = MemAddrOut; obsWdata = MemWdataOut;
                        obsMask = MemWmask; obsWrite = MemReqWrite;
                    end else if (MemAddrOut !== obsAddr || MemWdataOut !== obsWdata ||
                                 MemWmask !== obsMask || MemReqWrite !== obsWrite) begin
                        obsStable = 1'b0;
                    end
                    if (reqCnt == reqWait) begin
                        MemReqReady = 1'b1; MemRspValid = 1'b0;
                    end else begin
                        MemRspValid = spur; MemRdataIn = ~rdata;
                    end
                    reqCnt++;
                end
                @(posedge clk); #1;
                if (MemReqReady) begin
                    MemReqReady = 1'b0;
                    repeat (rspWait - 1) begin @(posedge clk); #1; end
                    MemRspValid = 1'b1; MemRdataIn = rdata;
                    @(posedge clk); #1;
                    MemRspValid = 1'b0;
                end
            end
        end
        checks++;
        if (!obsDone) begin
            errors++;
            $display("FAIL op_timeout got OutValid=0 want OutValid=1 within 60 cycles");
        end
        OutReady = 1'b1;
        @(posedge clk); #1;
        OutReady = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (allOuts !== '0) begin
            errors++; $display("FAIL reset_outputs got %h want 0", allOuts);
        end
        checks++;
        if (InReady !== 1'b1) begin
            errors++; $display("FAIL reset_inready got %b want 1", InReady);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_load_sign();
        do_op(OPC_LD, 3'b000, 64'h1000, 64'h3, 64'h0, 64'h0, 5'd7, 1'b1, 0, 1, 1'b0,
              64'h1122_3344_8055_6677);
        checks++;
        if (obsReq !== 1'b1 || obsAddr !== 64'h1003 || obsWrite !== 1'b0) begin
            errors++; $display("FAIL lb_req got req=%b addr=%h wr=%b want 1 1003 0", obsReq, obsAddr, obsWrite);
        end
        checks++;
        if (obsData !== 64'hFFFF_FFFF_FFFF_FF80 || obsWe !== 1'b1 || obsFault !== 1'b0 || obsRd !== 5'd7) begin
            errors++; $display("FAIL lb_wb got data=%h we=%b fault=%b rd=%0d want ffffffffffffff80 1 0 7",
                               obsData, obsWe, obsFault, obsRd);
        end
    endtask

    task automatic test_store();
        do_op(OPC_ST, 3'b001, 64'h1000, 64'h6, 64'hFFFF_0000_1234_ABCD, 64'h0, 5'd9, 1'b1, 0, 1, 1'b0,
              64'h0);
        checks++;
        if (obsReq !== 1'b1 || obsMask !== 8'hC0 || obsWrite !== 1'b1 || obsAddr !== 64'h1006) begin
            errors++; $display("FAIL sh_req got req=%b mask=%h wr=%b addr=%h want 1 c0 1 1006",
                               obsReq, obsMask, obsWrite, obsAddr);
        end
        checks++;
        if (obsWdata !== 64'hABCD_0000_0000_0000) begin
            errors++; $display("FAIL sh_wdata got %h want abcd000000000000", obsWdata);
        end
        checks++;
        if (obsWe !== 1'b0 || obsFault !== 1'b0) begin
            errors++; $display("FAIL sh_ack got we=%b fault=%b want 0 0", obsWe, obsFault);
        end
    endtask

    task automatic test_misaligned();
        do_op(OPC_LD, 3'b010, 64'h1000, 64'h2, 64'h0, 64'h0, 5'd5, 1'b1, 0, 1, 1'b0, 64'h0);
        checks++;
        if (obsReq !== 1'b0) begin
            errors++; $display("FAIL lw_misaligned_req got MemReqValid seen=%b want 0", obsReq);
        end
        checks++;
        if (obsFault !== 1'b1 || obsWe !== 1'b0 || obsDoneCyc != 0) begin
            errors++; $display("FAIL lw_misaligned_wb got fault=%b we=%b donecyc=%0d want 1 0 0",
                               obsFault, obsWe, obsDoneCyc);
        end
    endtask

    task automatic test_stall();
        do_op(OPC_LD, 3'b011, 64'h3000, 64'h8, 64'h0, 64'h0, 5'd11, 1'b1, 3, 2, 1'b1,
              64'h8877_6655_4433_2211);
        checks++;
        if (obsStable !== 1'b1 || obsAddr !== 64'h3008 || obsMask !== 8'hFF) begin
            errors++; $display("FAIL ld_stall_req got stable=%b addr=%h mask=%h want 1 3008 ff",
                               obsStable, obsAddr, obsMask);
        end
        checks++;
        if (obsData !== 64'h8877_6655_4433_2211 || obsWe !== 1'b1) begin
            errors++; $display("FAIL ld_stall_data got %h we=%b want 8877665544332211 1", obsData, obsWe);
        end
        do_op(OPC_LD, 3'b101, 64'h4000, 64'h2, 64'h0, 64'h0, 5'd12, 1'b1, 0, 1, 1'b0,
              64'hDEAD_BEEF_8001_1234);
        checks++;
        if (obsData !== 64'h0000_0000_0000_8001) begin
            errors++; $display("FAIL lhu_data got %h want 0000000000008001", obsData);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] vals [6];
        for (int i = 0; i < 6; i++) vals[i] = {$urandom, $urandom};
        OutReady = 1'b0; OpCodeIn = OPC_ALU; Funct3In = 3'b000; RdWriteEnableIn = 1'b1;
        RdAddrIn = 5'd3; RdWriteDataIn = vals[0]; InValid = 1'b1;
        @(posedge clk); #1;
        RdWriteDataIn = vals[1]; RdAddrIn = 5'd4;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (InReady !== 1'b0 || OutValid !== 1'b1 || RdWriteDataOut !== vals[0] || RdAddrOut !== 5'd3) begin
                errors++;
                $display("FAIL hold_c%0d got inrdy=%b ov=%b data=%h rd=%0d want 0 1 %h 3",
                         c, InReady, OutValid, RdWriteDataOut, RdAddrOut, vals[0]);
            end
        end
        @(posedge clk); #1;
        OutReady = 1'b1;
        for (int i = 1; i < 6; i++) begin
            @(posedge clk); #1;
            if (i < 5) RdWriteDataIn = vals[i+1];
            else       InValid = 1'b0;
            @(negedge clk);
            checks++;
            if (OutValid !== 1'b1 || RdWriteDataOut !== vals[i] || InReady !== 1'b1) begin
                errors++;
                $display("FAIL b2b_%0d got ov=%b data=%h inrdy=%b want 1 %h 1",
                         i, OutValid, RdWriteDataOut, InReady, vals[i]);
            end
        end
        @(posedge clk); #1;
        OutReady = 1'b0;
    endtask

    task automatic test_reset_mid();
        OpCodeIn = OPC_LD; Funct3In = 3'b011; Rs1ReadDataIn = 64'h2000; ImmIn = 64'h0;
        RdWriteEnableIn = 1'b1; InValid = 1'b1;
        @(posedge clk); #1;
        InValid = 1'b0; MemReqReady = 1'b1;
        @(posedge clk); #1;
        MemReqReady = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (allOuts !== '0 || InReady !== 1'b1) begin
            errors++; $display("FAIL midreset_outputs got %h inrdy=%b want 0 1", allOuts, InReady);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; MemRspValid = 1'b1; MemRdataIn = {$urandom, $urandom};
        @(posedge clk); #1;
        MemRspValid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (OutValid !== 1'b0 || MemReqValid !== 1'b0) begin
                errors++; $display("FAIL midreset_drop_c%0d got ov=%b req=%b want 0 0", c, OutValid, MemReqValid);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [63:0] rs1, imm, rs2, alu, rdata;
        logic [4:0]  rd;
        logic        we, eReq, eFault, eWe;
        logic [63:0] eAddr, eWdata, eData;
        logic [7:0]  eMask;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 2))
                0:       op = OPC_LD;
                1:       op = OPC_ST;
                default: op = OPC_ALU;
            endcase
            f3    = 3'($urandom_range(0, 7));
            rs1   = {$urandom, $urandom} & ~64'h7;
            imm   = 64'(int'($urandom_range(0, 15)) - 8);
            rs2   = {$urandom, $urandom};
            alu   = {$urandom, $urandom};
            rdata = {$urandom, $urandom};
            rd    = 5'($urandom_range(0, 31));
            we    = 1'($urandom_range(0, 1));
            model(op, f3, rs1, imm, rs2, rdata, alu, we, eReq, eFault, eWe, eAddr, eWdata, eData, eMask);
            do_op(op, f3, rs1, imm, rs2, alu, rd, we, $urandom_range(0, 3), $urandom_range(1, 3),
                  1'($urandom_range(0, 1)), rdata);
            checks++;
            if (obsReq !== eReq || obsFault !== eFault || obsWe !== eWe || obsRd !== rd) begin
                errors++;
                $display("FAIL rnd%0d_ctrl got req=%b fault=%b we=%b rd=%0d want %b %b %b %0d",
                         n, obsReq, obsFault, obsWe, obsRd, eReq, eFault, eWe, rd);
            end
            if (eReq) begin
                checks++;
                if (obsAddr !== eAddr || obsMask !== eMask || obsWrite !== (op == OPC_ST) || obsStable !== 1'b1 ||
                    (op == OPC_ST && obsWdata !== eWdata)) begin
                    errors++;
                    $display("FAIL rnd%0d_req got addr=%h mask=%h wr=%b wd=%h st=%b want %h %h %b %h 1",
                             n, obsAddr, obsMask, obsWrite, obsWdata, obsStable, eAddr, eMask, op == OPC_ST, eWdata);
                end
            end
            if (!eFault && op != OPC_ST) begin
                checks++;
                if (obsData !== eData) begin
                    errors++; $display("FAIL rnd%0d_data got %h want %h", n, obsData, eData);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; InValid = 1'b0; RdWriteDataIn = '0; RdAddrIn = '0; RdWriteEnableIn = 1'b0;
        ImmIn = '0; OpCodeIn = '0; Funct3In = '0; Rs1ReadDataIn = '0; Rs2ReadDataIn = '0;
        OutReady = 1'b0; MemReqReady = 1'b0; MemRspValid = 1'b0; MemRdataIn = '0;
        test_reset();
        test_load_sign();
        test_store();
        test_misaligned();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no finish want finish before 500000");
        $fatal(1);
    end
endmodule
